id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand forwarding and load-use hazard detection.
//  Sits between decode and the ALU: latches decoded fields and selects the final a/b operands.
//  Feeds the ALU's aluop/a_i/b_i inputs.
//  Also returns the stall request that freezes IF/ID on a load-use hazard.
// PARAMETERS
//  XLEN      32  datapath width (a_o, b_o, immediates, PC)
//  REGADDR   5   register-index width
// PORTS
//  clk_i          in   1      clock, all state updates on rising edge
//  rst_i          in   1      reset, asynchronous, active-high
//  stall_i        in   1      global freeze (cache miss); hold all state
//  flush_i        in   1      branch/jump taken; load a bubble
//  id_valid_i     in   1      decode holds a real instruction
//  id_rs1_i       in   5      source register 1 index
//  id_rs2_i       in   5      source register 2 index
//  id_rd_i        in   5      destination register index
//  id_rs1_data_i  in   XLEN   register-file read data 1
//  id_rs2_data_i  in   XLEN   register-file read data 2
//  id_imm_i       in   XLEN   sign-extended immediate
//  id_pc_i        in   XLEN   instruction PC
//  id_aluop_i     in   4      ALU opcode (ADD 0000, SUB 0001, SLL 0010, SLT 0100, XOR 1000,
//                             SRL 1010, SRA 1011, OR 1100, AND 1110)
//  id_alusrc_i    in   1      1: b operand = imm; 0: b operand = rs2
//  id_asrc_pc_i   in   1      1: a operand = PC (AUIPC/JAL)
//  id_regwrite_i  in   1      instruction writes rd
//  id_memread_i   in   1      instruction is a load
//  id_memwrite_i  in   1      instruction is a store
//  exmem_rd_i     in   5      EX/MEM destination index
//  exmem_we_i     in   1      EX/MEM writes rd
//  exmem_data_i   in   XLEN   EX/MEM ALU result
//  memwb_rd_i     in   5      MEM/WB destination index
//  memwb_we_i     in   1      MEM/WB writes rd
//  memwb_data_i   in   XLEN   MEM/WB writeback data
//  hazard_stall_o out  1      load-use stall to PC and IF/ID (combinational)
//  aluop_o        out  4      registered opcode to ALU
//  a_o            out  XLEN   forwarded ALU operand a
//  b_o            out  XLEN   forwarded ALU operand b
//  store_data_o   out  XLEN   forwarded rs2 for stores
//  ex_rd_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_valid_o  out  5/1/1/1/1  registered controls
// BEHAVIOUR
//  Reset: all registers cleared to a bubble. Outputs: valid/regwrite/memread/memwrite=0,
//   rd=0, aluop=ADD, a_o=b_o=store_data_o=0, hazard_stall_o=0.
//  Bubble: valid=0, regwrite=0, memread=0, memwrite=0, rd=0, aluop=ADD, data fields 0.
//  Register update priority per edge: stall_i hold > flush_i bubble > hazard bubble > load ID fields.
//  Load-use hazard = ex_memread_o & ex_valid_o & ex_rd_o!=0 & id_valid_i
//   & (ex_rd_o==id_rs1_i | (ex_rd_o==id_rs2_i & !id_alusrc_i | id_memwrite_i)).
//  hazard_stall_o = hazard & !flush_i. A hazard costs exactly 1 bubble; the next cycle it clears.
//  Forwarding (combinational on registered rs1/rs2) for each source:
//   EX/MEM if exmem_we_i & rd!=0 & match; else MEM/WB if memwb_we_i & rd!=0 & match; else register data.
//   EX/MEM wins when both stages match. x0 is never forwarded.
//  a_o = asrc_pc ? pc : fwd_rs1.  b_o = alusrc ? imm : fwd_rs2.  store_data_o = fwd_rs2 always.
//  Shifts (SLL/SRL/SRA): b_o is zero-extended from b[4:0], so the ALU sees shift amounts 0..31 only.
//  Latency: ID fields reach the ALU inputs 1 cycle after capture. Forward paths add 0 cycles.
//  Reset asserted mid-operation discards the in-flight instruction immediately (async).
// TESTING
//  ADD x3,x1,x2 with EX/MEM rd=1 data=0x10, MEM/WB rd=1 data=0x20 -> a_o=0x10 (EX/MEM priority).
//  EX holds LW x5, ID has ADD x6,x5,x0 -> hazard_stall_o=1 for 1 cycle, then bubble (valid=0);
//   next cycle the ADD is loaded and MEM/WB forwards x5.
//  Same load-use case with flush_i=1 -> hazard_stall_o=0, bubble loaded.
//  stall_i=1 for 3 cycles -> all outputs are held unchanged.
//  SLL with imm=0x00000123 -> b_o=0x00000003.
//  EX/MEM rd=0 we=1 data=0xDEAD, ID rs1=0, rf data 0 -> a_o=0.
//  rst_i pulsed mid-cycle -> outputs go to the bubble values at once, without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
// Groups the signals of the ID/EX stage into one bundle. Decode, the hazard and
// flush sources, and the bypass taps drive it (master). The ID/EX stage reads
// it and drives the ALU-facing results (slave).
//   control : stall_i, flush_i, hazard_stall_o
//   decode  : id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_rs1_data_i,
//             id_rs2_data_i, id_imm_i, id_pc_i, id_aluop_i, id_alusrc_i,
//             id_asrc_pc_i, id_regwrite_i, id_memread_i, id_memwrite_i
//   bypass  : exmem_rd_i, exmem_we_i, exmem_data_i,
//             memwb_rd_i, memwb_we_i, memwb_data_i
//   to ALU  : aluop_o, a_o, b_o, store_data_o, ex_rd_o, ex_regwrite_o,
//             ex_memread_o, ex_memwrite_o, ex_valid_o
interface id_ex_stage_if #(
    parameter int XLEN    = 32,
    parameter int REGADDR = 5
);
    logic               stall_i;
    logic               flush_i;
    logic               id_valid_i;
    logic [REGADDR-1:0] id_rs1_i;
    logic [REGADDR-1:0] id_rs2_i;
    logic [REGADDR-1:0] id_rd_i;
    logic [XLEN-1:0]    id_rs1_data_i;
    logic [XLEN-1:0]    id_rs2_data_i;
    logic [XLEN-1:0]    id_imm_i;
    logic [XLEN-1:0]    id_pc_i;
    logic [3:0]         id_aluop_i;
    logic               id_alusrc_i;
    logic               id_asrc_pc_i;
    logic               id_regwrite_i;
    logic               id_memread_i;
    logic               id_memwrite_i;
    logic [REGADDR-1:0] exmem_rd_i;
    logic               exmem_we_i;
    logic [XLEN-1:0]    exmem_data_i;
    logic [REGADDR-1:0] memwb_rd_i;
    logic               memwb_we_i;
    logic [XLEN-1:0]    memwb_data_i;
    logic               hazard_stall_o;
    logic [3:0]         aluop_o;
    logic [XLEN-1:0]    a_o;
    logic [XLEN-1:0]    b_o;
    logic [XLEN-1:0]    store_data_o;
    logic [REGADDR-1:0] ex_rd_o;
    logic               ex_regwrite_o;
    logic               ex_memread_o;
    logic               ex_memwrite_o;
    logic               ex_valid_o;

    modport master (
        output stall_i, flush_i, id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i, id_aluop_i,
               id_alusrc_i, id_asrc_pc_i, id_regwrite_i, id_memread_i,
               id_memwrite_i, exmem_rd_i, exmem_we_i, exmem_data_i,
               memwb_rd_i, memwb_we_i, memwb_data_i,
        input  hazard_stall_o, aluop_o, a_o, b_o, store_data_o, ex_rd_o,
               ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_valid_o
    );

    modport slave (
        input  stall_i, flush_i, id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i, id_aluop_i,
               id_alusrc_i, id_asrc_pc_i, id_regwrite_i, id_memread_i,
               id_memwrite_i, exmem_rd_i, exmem_we_i, exmem_data_i,
               memwb_rd_i, memwb_we_i, memwb_data_i,
        output hazard_stall_o, aluop_o, a_o, b_o, store_data_o, ex_rd_o,
               ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_valid_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard
// detection. It latches the decoded instruction, then picks the final ALU a/b
// operands and the store data from the EX/MEM and MEM/WB bypass taps.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset, clears the stage to a bubble
//   bus   : id_ex_stage_if slave port (decode fields, bypass taps, ALU outputs,
//           hazard_stall_o back to PC and IF/ID)
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int REGADDR = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    id_ex_stage_if.slave  bus
);

    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;

    // An all-zero value of this record is the bubble. ADD is opcode 0000, so
    // it needs no special encoding.
    typedef struct packed {
        logic               valid;
        logic [REGADDR-1:0] rs1;
        logic [REGADDR-1:0] rs2;
        logic [REGADDR-1:0] rd;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic [3:0]         aluop;
        logic               alusrc;
        logic               asrc_pc;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
    } ex_reg_t;

    ex_reg_t         ex_q;
    ex_reg_t         id_fields;
    logic            load_use;
    logic            rs2_used;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] b_sel;
    logic            is_shift;

    // The side-effecting controls are gated by id_valid_i, so an empty decode
    // slot can never write a register or touch memory.
    always_comb begin
        id_fields          = '0;
        id_fields.valid    = bus.id_valid_i;
        id_fields.rs1      = bus.id_rs1_i;
        id_fields.rs2      = bus.id_rs2_i;
        id_fields.rd       = bus.id_rd_i;
        id_fields.rs1_data = bus.id_rs1_data_i;
        id_fields.rs2_data = bus.id_rs2_data_i;
        id_fields.imm      = bus.id_imm_i;
        id_fields.pc       = bus.id_pc_i;
        id_fields.aluop    = bus.id_aluop_i;
        id_fields.alusrc   = bus.id_alusrc_i;
        id_fields.asrc_pc  = bus.id_asrc_pc_i;
        id_fields.regwrite = bus.id_regwrite_i & bus.id_valid_i;
        id_fields.memread  = bus.id_memread_i & bus.id_valid_i;
        id_fields.memwrite = bus.id_memwrite_i & bus.id_valid_i;
    end

    // Load-use check against the load sitting in EX. rs2 counts as read when
    // it feeds the b operand or when the decode instruction is a store, since
    // then rs2 is the store data.
    always_comb begin
        rs2_used = !bus.id_alusrc_i || bus.id_memwrite_i;
        load_use = ex_q.memread && ex_q.valid && (ex_q.rd != '0) &&
                   bus.id_valid_i &&
                   ((ex_q.rd == bus.id_rs1_i) ||
                    ((ex_q.rd == bus.id_rs2_i) && rs2_used));
    end

    assign bus.hazard_stall_o = load_use && !bus.flush_i;

    // Update priority: a global stall holds everything, then a flush or a
    // load-use hazard inserts a bubble. Otherwise the ID fields are loaded.
    // After a hazard bubble, EX is no longer valid, so the hazard clears on
    // the next cycle by itself.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else if (bus.stall_i) begin
            ex_q <= ex_q;
        end else if (bus.flush_i || load_use) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_fields;
        end
    end

    // Forwarding on the registered sources. EX/MEM is younger, so it beats
    // MEM/WB. x0 always reads the register-file value, which is zero.
    always_comb begin
        fwd_rs1 = ex_q.rs1_data;
        if (bus.exmem_we_i && (bus.exmem_rd_i != '0) && (bus.exmem_rd_i == ex_q.rs1)) begin
            fwd_rs1 = bus.exmem_data_i;
        end else if (bus.memwb_we_i && (bus.memwb_rd_i != '0) && (bus.memwb_rd_i == ex_q.rs1)) begin
            fwd_rs1 = bus.memwb_data_i;
        end

        fwd_rs2 = ex_q.rs2_data;
        if (bus.exmem_we_i && (bus.exmem_rd_i != '0) && (bus.exmem_rd_i == ex_q.rs2)) begin
            fwd_rs2 = bus.exmem_data_i;
        end else if (bus.memwb_we_i && (bus.memwb_rd_i != '0) && (bus.memwb_rd_i == ex_q.rs2)) begin
            fwd_rs2 = bus.memwb_data_i;
        end
    end

    // Shift amounts are trimmed to b[4:0] here so the ALU never sees a shift
    // count above 31.
    always_comb begin
        is_shift = (ex_q.aluop == OP_SLL) || (ex_q.aluop == OP_SRL) || (ex_q.aluop == OP_SRA);
        b_sel    = ex_q.alusrc ? ex_q.imm : fwd_rs2;
        bus.b_o  = is_shift ? {{(XLEN-5){1'b0}}, b_sel[4:0]} : b_sel;
    end

    assign bus.a_o           = ex_q.asrc_pc ? ex_q.pc : fwd_rs1;
    assign bus.store_data_o  = fwd_rs2;
    assign bus.aluop_o       = ex_q.aluop;
    assign bus.ex_rd_o       = ex_q.rd;
    assign bus.ex_regwrite_o = ex_q.regwrite;
    assign bus.ex_memread_o  = ex_q.memread;
    assign bus.ex_memwrite_o = ex_q.memwrite;
    assign bus.ex_valid_o    = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Self-checking bench for id_ex_stage. A record-level model of the EX
// instruction is compared against the DUT on every falling edge. Directed
// scenarios add hand-computed literal expectations.
module tb_id_ex_stage;

    logic clk;
    logic rst;
    logic model_on;
    int   check_count;
    int   pass_count;

    id_ex_stage_if #(.XLEN(32), .REGADDR(5)) bus ();

    id_ex_stage #(.XLEN(32), .REGADDR(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  op;
        logic        alusrc;
        logic        asrc;
        logic        rw;
        logic        mr;
        logic        mw;
    } instr_t;

    instr_t m_ex;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // A source reads the youngest in-flight producer of its register. x0 reads
    // zero from the register file.
    function automatic logic [31:0] newest_value(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return rf;
        if (bus.exmem_we_i && bus.exmem_rd_i == idx) return bus.exmem_data_i;
        if (bus.memwb_we_i && bus.memwb_rd_i == idx) return bus.memwb_data_i;
        return rf;
    endfunction

    function automatic logic model_hazard(input instr_t ex);
        logic reads_rs2;
        reads_rs2 = !bus.id_alusrc_i || bus.id_memwrite_i;
        return ex.valid && ex.mr && ex.rd != 5'd0 && bus.id_valid_i &&
               (ex.rd == bus.id_rs1_i || (ex.rd == bus.id_rs2_i && reads_rs2));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ex <= '0;
        end else if (bus.stall_i) begin
            m_ex <= m_ex;
        end else if (bus.flush_i || model_hazard(m_ex)) begin
            m_ex <= '0;
        end else begin
            m_ex <= '{valid: bus.id_valid_i, rs1: bus.id_rs1_i, rs2: bus.id_rs2_i,
                      rd: bus.id_rd_i, d1: bus.id_rs1_data_i, d2: bus.id_rs2_data_i,
                      imm: bus.id_imm_i, pc: bus.id_pc_i, op: bus.id_aluop_i,
                      alusrc: bus.id_alusrc_i, asrc: bus.id_asrc_pc_i,
                      rw: bus.id_regwrite_i && bus.id_valid_i,
                      mr: bus.id_memread_i && bus.id_valid_i,
                      mw: bus.id_memwrite_i && bus.id_valid_i};
        end
    end

    always @(negedge clk) begin
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] bval;
        if (model_on && !rst) begin
            src1 = newest_value(m_ex.rs1, m_ex.d1);
            src2 = newest_value(m_ex.rs2, m_ex.d2);
            bval = m_ex.alusrc ? m_ex.imm : src2;
            if (m_ex.op == 4'b0010 || m_ex.op == 4'b1010 || m_ex.op == 4'b1011) begin
                bval = bval % 32;
            end
            checkOutput("cmp_a", bus.a_o, m_ex.asrc ? m_ex.pc : src1);
            checkOutput("cmp_b", bus.b_o, bval);
            checkOutput("cmp_store", bus.store_data_o, src2);
            checkOutput("cmp_aluop", {28'd0, bus.aluop_o}, {28'd0, m_ex.op});
            checkOutput("cmp_rd", {27'd0, bus.ex_rd_o}, {27'd0, m_ex.rd});
            checkOutput("cmp_ctrl",
                        {28'd0, bus.ex_valid_o, bus.ex_regwrite_o, bus.ex_memread_o, bus.ex_memwrite_o},
                        {28'd0, m_ex.valid, m_ex.rw, m_ex.mr, m_ex.mw});
            checkOutput("cmp_hazard", {31'd0, bus.hazard_stall_o},
                        {31'd0, model_hazard(m_ex) && !bus.flush_i});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearBypass();
        bus.exmem_rd_i   = '0;
        bus.exmem_we_i   = 1'b0;
        bus.exmem_data_i = '0;
        bus.memwb_rd_i   = '0;
        bus.memwb_we_i   = 1'b0;
        bus.memwb_data_i = '0;
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                 input logic [31:0] pc, input logic [3:0] op, input logic alusrc,
                                 input logic asrc, input logic rw, input logic mr, input logic mw);
        bus.id_valid_i    = 1'b1;
        bus.id_rs1_i      = rs1;
        bus.id_rs2_i      = rs2;
        bus.id_rd_i       = rd;
        bus.id_rs1_data_i = d1;
        bus.id_rs2_data_i = d2;
        bus.id_imm_i      = imm;
        bus.id_pc_i       = pc;
        bus.id_aluop_i    = op;
        bus.id_alusrc_i   = alusrc;
        bus.id_asrc_pc_i  = asrc;
        bus.id_regwrite_i = rw;
        bus.id_memread_i  = mr;
        bus.id_memwrite_i = mw;
    endtask

    task automatic setIdle();
        applyStimulus(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.id_valid_i = 1'b0;
    endtask

    task automatic issueLoadX5();
        applyStimulus(5'd1, 5'd0, 5'd5, 32'h1000, 32'd0, 32'd4, 32'h104, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        check_count = 0;
        pass_count  = 0;
        model_on    = 1'b0;
        rst         = 1'b1;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        setIdle();
        clearBypass();
        repeat (2) step();

        checkOutput("reset_valid", {31'd0, bus.ex_valid_o}, 32'd0);
        checkOutput("reset_a", bus.a_o, 32'd0);
        checkOutput("reset_b", bus.b_o, 32'd0);
        checkOutput("reset_store", bus.store_data_o, 32'd0);
        checkOutput("reset_hazard", {31'd0, bus.hazard_stall_o}, 32'd0);
        rst      = 1'b0;
        model_on = 1'b1;
        step();

        // ADD x3,x1,x2 with both bypass stages holding x1.
        applyStimulus(5'd1, 5'd2, 5'd3, 32'h111, 32'h222, 32'd0, 32'h100, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        setIdle();
        bus.exmem_rd_i = 5'd1; bus.exmem_we_i = 1'b1; bus.exmem_data_i = 32'h10;
        bus.memwb_rd_i = 5'd1; bus.memwb_we_i = 1'b1; bus.memwb_data_i = 32'h20;
        #1;
        checkOutput("fwd_exmem_prio_a", bus.a_o, 32'h10);
        checkOutput("fwd_none_b", bus.b_o, 32'h222);
        bus.memwb_rd_i = 5'd2;
        #1;
        checkOutput("fwd_memwb_b", bus.b_o, 32'h20);
        clearBypass();
        step();

        // LW x5 in EX, ADD x6,x5,x0 in ID.
        issueLoadX5();
        step();
        applyStimulus(5'd5, 5'd0, 5'd6, 32'hBAD, 32'd0, 32'd0, 32'h108, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("loaduse_stall", {31'd0, bus.hazard_stall_o}, 32'd1);
        step();
        checkOutput("loaduse_bubble", {31'd0, bus.ex_valid_o}, 32'd0);
        checkOutput("loaduse_cleared", {31'd0, bus.hazard_stall_o}, 32'd0);
        bus.memwb_rd_i = 5'd5; bus.memwb_we_i = 1'b1; bus.memwb_data_i = 32'h55;
        step();
        checkOutput("loaduse_add_valid", {31'd0, bus.ex_valid_o}, 32'd1);
        checkOutput("loaduse_add_rd", {27'd0, bus.ex_rd_o}, 32'd6);
        checkOutput("loaduse_memwb_fwd", bus.a_o, 32'h55);
        setIdle();
        clearBypass();
        step();

        // Same load-use pair while a flush is taken.
        issueLoadX5();
        step();
        applyStimulus(5'd5, 5'd0, 5'd6, 32'hBAD, 32'd0, 32'd0, 32'h108, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.flush_i = 1'b1;
        #1;
        checkOutput("flush_no_stall", {31'd0, bus.hazard_stall_o}, 32'd0);
        step();
        checkOutput("flush_bubble", {31'd0, bus.ex_valid_o}, 32'd0);
        bus.flush_i = 1'b0;
        setIdle();
        step();

        // Store whose data register is the pending load: rs2 matters despite alusrc.
        issueLoadX5();
        step();
        applyStimulus(5'd2, 5'd5, 5'd0, 32'h40, 32'hBAD, 32'd8, 32'h10C, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("store_loaduse_stall", {31'd0, bus.hazard_stall_o}, 32'd1);
        step();
        setIdle();
        step();

        // SUB x7,x1,x2 held through three stalled cycles.
        applyStimulus(5'd1, 5'd2, 5'd7, 32'd100, 32'd30, 32'd0, 32'h200, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        bus.stall_i = 1'b1;
        applyStimulus(5'd3, 5'd4, 5'd9, 32'd7, 32'd8, 32'd0, 32'h204, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        checkOutput("stall_a", bus.a_o, 32'd100);
        checkOutput("stall_b", bus.b_o, 32'd30);
        checkOutput("stall_aluop", {28'd0, bus.aluop_o}, 32'd1);
        checkOutput("stall_rd", {27'd0, bus.ex_rd_o}, 32'd7);
        bus.stall_i = 1'b0;
        step();

        // Shift amounts are trimmed to five bits.
        applyStimulus(5'd1, 5'd0, 5'd8, 32'd1, 32'd0, 32'h123, 32'h300, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("sll_imm_shamt", bus.b_o, 32'h3);
        applyStimulus(5'd1, 5'd2, 5'd8, 32'd1, 32'hFFFFFFE5, 32'd0, 32'h304, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("sra_reg_shamt", bus.b_o, 32'h5);
        checkOutput("sra_store_data", bus.store_data_o, 32'hFFFFFFE5);

        // x0 is never forwarded.
        bus.exmem_rd_i = 5'd0; bus.exmem_we_i = 1'b1; bus.exmem_data_i = 32'hDEAD;
        applyStimulus(5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 32'h308, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("x0_no_fwd", bus.a_o, 32'd0);
        clearBypass();

        // AUIPC-style: a from PC, b from immediate.
        applyStimulus(5'd1, 5'd0, 5'd10, 32'hBAD, 32'd0, 32'h5000, 32'h1000, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("auipc_a", bus.a_o, 32'h1000);
        checkOutput("auipc_b", bus.b_o, 32'h5000);

        // Asynchronous reset in the middle of a cycle.
        applyStimulus(5'd1, 5'd2, 5'd11, 32'h77, 32'h88, 32'd0, 32'h400, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("pre_reset_valid", {31'd0, bus.ex_valid_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_valid", {31'd0, bus.ex_valid_o}, 32'd0);
        checkOutput("async_reset_a", bus.a_o, 32'd0);
        checkOutput("async_reset_aluop", {28'd0, bus.aluop_o}, 32'd0);
        checkOutput("async_reset_regwrite", {31'd0, bus.ex_regwrite_o}, 32'd0);
        step();
        rst = 1'b0;
        setIdle();
        repeat (2) step();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
